// File: rtl/enemy_shot_arb_pkg.sv
// Shared game constants: VGA timing, the enemy-shot state encoding and the
// pseudo-random generator definition used to pick a shooting column.
package enemy_shot_arb_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SELECT = 2'd2,
        FIRE   = 2'd3
    } shot_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1 in a left-shifting Fibonacci register taps bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/enemy_shot_arb_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; the nonzero seed keeps it on the
// 255-state maximal cycle so it never locks up at zero.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);
    import enemy_shot_arb_pkg::*;

    logic [7:0] r_q;

    // Advance once per clock, independent of the game tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[6:0], lfsr_feedback(r_q)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/enemy_shot_arb.sv
// Enemy shot arbiter: after a tick-based cooldown, picks a random live invader
// column and the lowest free bullet engine, then issues a one-cycle launch.
module enemy_shot_arb #(
    parameter int NUM_COLS       = 11,
    parameter int NUM_SLOTS      = 2,
    parameter int COOLDOWN_TICKS = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 game_run,
    input  logic [NUM_COLS-1:0]  col_alive,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic [NUM_SLOTS-1:0] fire,
    output logic [3:0]           fire_col,
    output logic [NUM_SLOTS-1:0] slot_busy
);
    import enemy_shot_arb_pkg::*;

    localparam int             CD_W    = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_TICKS);

    shot_state_e          r_state;
    logic [CD_W-1:0]      r_cooldown;
    logic [3:0]           r_start;
    logic [NUM_SLOTS-1:0] r_fire;
    logic [3:0]           r_fire_col;
    logic [NUM_SLOTS-1:0] r_busy;

    logic [7:0]           w_lfsr;
    logic                 w_lfsr_ok;
    logic [4:0]           w_start_sum;
    logic [3:0]           w_start_red;
    logic [NUM_COLS-1:0]  w_rot;
    logic                 w_col_found;
    logic [4:0]           w_offset;
    logic [4:0]           w_col_sum;
    logic [3:0]           w_col;
    logic [NUM_SLOTS-1:0] w_slot_mask;
    logic                 w_any_free;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    // Fold the random nibble into the column range for the search start point.
    always_comb begin
        w_lfsr_ok   = |w_lfsr;
        w_start_sum = {1'b0, w_lfsr[3:0]};
        if (w_start_sum >= 5'(NUM_COLS)) begin
            w_start_red = 4'(w_start_sum - 5'(NUM_COLS));
        end else begin
            w_start_red = w_lfsr[3:0];
        end
    end

    // Rotate alive columns so the start sits at bit 0; the lowest set bit is the wrap-around first hit.
    always_comb begin
        w_rot       = NUM_COLS'({col_alive, col_alive} >> r_start);
        w_col_found = 1'b0;
        w_offset    = 5'd0;
        for (int k = NUM_COLS - 1; k >= 0; k--) begin
            w_col_found = w_col_found | w_rot[k];
            w_offset    = w_rot[k] ? 5'(k) : w_offset;
        end
        w_col_sum = 5'(r_start) + w_offset;
        if (w_col_sum >= 5'(NUM_COLS)) begin
            w_col = 4'(w_col_sum - 5'(NUM_COLS));
        end else begin
            w_col = 4'(w_col_sum);
        end
    end

    // Lowest-indexed free bullet engine as a one-hot mask.
    always_comb begin
        w_any_free  = ~&r_busy;
        w_slot_mask = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            w_slot_mask = r_busy[s] ? w_slot_mask : (NUM_SLOTS'(1) << s);
        end
    end

    // Control FSM with registered launch outputs and slot ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cooldown <= '0;
            r_start    <= 4'd0;
            r_fire     <= '0;
            r_fire_col <= 4'd0;
            r_busy     <= '0;
        end else begin
            r_fire     <= '0;
            r_fire_col <= 4'd0;
            r_busy     <= r_busy & ~slot_done;
            if (!game_run) begin
                r_state <= IDLE;
                r_busy  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= WAIT;
                        r_cooldown <= CD_LOAD;
                        r_busy     <= '0;
                    end
                    WAIT: begin
                        if (r_cooldown == '0) begin
                            // A dead generator would be a fault; hold rather than fire from it.
                            if (w_any_free && (|col_alive) && w_lfsr_ok) begin
                                r_state <= SELECT;
                                r_start <= w_start_red;
                            end else begin
                                r_state <= WAIT;
                            end
                        end else if (tick) begin
                            r_cooldown <= r_cooldown - CD_W'(1);
                        end else begin
                            r_cooldown <= r_cooldown;
                        end
                    end
                    SELECT: begin
                        r_state <= FIRE;
                        if (w_col_found && (|w_slot_mask)) begin
                            r_fire     <= w_slot_mask;
                            r_fire_col <= w_col;
                            r_busy     <= (r_busy & ~slot_done) | w_slot_mask;
                            r_cooldown <= CD_LOAD;
                        end else begin
                            r_cooldown <= r_cooldown;
                        end
                    end
                    FIRE: begin
                        r_state <= WAIT;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign fire      = r_fire;
    assign fire_col  = r_fire_col;
    assign slot_busy = r_busy;

endmodule
